// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, flag bit
// positions, FSM state type and opcode classification helpers.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 4;
   localparam int FLAG_W = 4;

   // Opcode encodings understood by the external ALU
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_INC  = 4'b1010;
   localparam logic [3:0] OP_DEC  = 4'b1011;
   localparam logic [3:0] OP_SRA  = 4'b1101;

   // Bit positions inside the response flag vector {ZF,CF,OF,SF}
   localparam int FLAG_ZF = 3;
   localparam int FLAG_CF = 2;
   localparam int FLAG_OF = 1;
   localparam int FLAG_SF = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // True for every opcode the ALU implements
   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      logic r;
      case (op)
         OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
         OP_OR, OP_AND, OP_SUB, OP_INC, OP_DEC, OP_SRA: r = 1'b1;
         default:                                       r = 1'b0;
      endcase
      return r;
   endfunction

   // True for the opcodes whose carry/overflow flags are meaningful
   function automatic logic is_arith_op(input logic [OP_W-1:0] op);
      logic r;
      case (op)
         OP_ADD, OP_SUB, OP_INC, OP_DEC: r = 1'b1;
         default:                        r = 1'b0;
      endcase
      return r;
   endfunction

   // Assemble response flags; CF/OF are forced low for non-arithmetic ops
   function automatic logic [FLAG_W-1:0] clean_flags(
      input logic [OP_W-1:0] op,
      input logic            zf,
      input logic            cf,
      input logic            of,
      input logic            sf
   );
      logic [FLAG_W-1:0] f;
      f          = 4'b0000;
      f[FLAG_ZF] = zf;
      f[FLAG_SF] = sf;
      if (is_arith_op(op)) begin
         f[FLAG_CF] = cf;
         f[FLAG_OF] = of;
      end else begin
         f[FLAG_CF] = 1'b0;
         f[FLAG_OF] = 1'b0;
      end
      return f;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer port wins a tie; after any
// accepted grant the pointer moves to the other port.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   logic       r_ptr;
   logic [1:0] w_gnt;

   // Grant the pointer port if it requests, otherwise the other one
   always_comb begin
      w_gnt = 2'b00;
      if (i_en) begin
         case (r_ptr)
            1'b0: begin
               if (i_req[0])      w_gnt = 2'b01;
               else if (i_req[1]) w_gnt = 2'b10;
               else               w_gnt = 2'b00;
            end
            1'b1: begin
               if (i_req[1])      w_gnt = 2'b10;
               else if (i_req[0]) w_gnt = 2'b01;
               else               w_gnt = 2'b00;
            end
            default: w_gnt = 2'b00;
         endcase
      end else begin
         w_gnt = 2'b00;
      end
   end

   // Pointer moves to the loser whenever a grant is taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else if (|w_gnt) begin
         r_ptr <= w_gnt[0];
      end else begin
         r_ptr <= r_ptr;
      end
   end

   assign o_gnt = w_gnt;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready
// requesters. Operands are registered toward the ALU, the result is
// captured one cycle later and held on a tagged response channel until
// the consumer accepts it. Illegal opcodes bypass the ALU entirely.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   // requester 0: integer execute path
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [31:0]       req0_a,
   input  logic [31:0]       req0_b,
   input  logic [3:0]        req0_op,
   input  logic [TAG_W-1:0]  req0_tag,
   // requester 1: auxiliary/debug path
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [31:0]       req1_a,
   input  logic [31:0]       req1_b,
   input  logic [3:0]        req1_op,
   input  logic [TAG_W-1:0]  req1_tag,
   // response channel
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic [31:0]       rsp_result,
   output logic [3:0]        rsp_flags,
   output logic              rsp_err,
   // external ALU
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   output logic [3:0]        alu_op,
   input  logic [31:0]       alu_out,
   input  logic              alu_zf,
   input  logic              alu_cf,
   input  logic              alu_of,
   input  logic              alu_sf
);

   state_t                r_state;
   logic [DATA_W-1:0]     r_alu_a;
   logic [DATA_W-1:0]     r_alu_b;
   logic [OP_W-1:0]       r_alu_op;
   logic                  r_rsp_valid;
   logic                  r_rsp_id;
   logic [TAG_W-1:0]      r_rsp_tag;
   logic [DATA_W-1:0]     r_rsp_result;
   logic [FLAG_W-1:0]     r_rsp_flags;
   logic                  r_rsp_err;

   logic                  w_arb_en;
   logic [1:0]            w_gnt;
   logic                  w_hs;
   logic                  w_sel_id;
   logic [DATA_W-1:0]     w_sel_a;
   logic [DATA_W-1:0]     w_sel_b;
   logic [OP_W-1:0]       w_sel_op;
   logic [TAG_W-1:0]      w_sel_tag;

   // Requests are only considered in IDLE; reset also masks ready so
   // nothing can look accepted while the block is held in reset.
   assign w_arb_en = (r_state == ST_IDLE) && rst_n;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_arb_en),
      .i_req ({req1_valid, req0_valid}),
      .o_gnt (w_gnt)
   );

   assign req0_ready = w_gnt[0];
   assign req1_ready = w_gnt[1];
   assign w_hs       = |w_gnt;

   // Route the granted port's request fields toward the FSM
   always_comb begin
      if (w_gnt[1]) begin
         w_sel_id  = 1'b1;
         w_sel_a   = req1_a;
         w_sel_b   = req1_b;
         w_sel_op  = req1_op;
         w_sel_tag = req1_tag;
      end else begin
         w_sel_id  = 1'b0;
         w_sel_a   = req0_a;
         w_sel_b   = req0_b;
         w_sel_op  = req0_op;
         w_sel_tag = req0_tag;
      end
   end

   // Issue/execute/respond sequencer with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_alu_a      <= 32'd0;
         r_alu_b      <= 32'd0;
         r_alu_op     <= 4'd0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_tag    <= '0;
         r_rsp_result <= 32'd0;
         r_rsp_flags  <= 4'd0;
         r_rsp_err    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hs) begin
                  r_rsp_id  <= w_sel_id;
                  r_rsp_tag <= w_sel_tag;
                  if (is_legal_op(w_sel_op)) begin
                     // ALU operands only change here, so the ALU
                     // never sees a stray opcode outside EXEC
                     r_alu_a  <= w_sel_a;
                     r_alu_b  <= w_sel_b;
                     r_alu_op <= w_sel_op;
                     r_state  <= ST_EXEC;
                  end else begin
                     r_rsp_result <= 32'd0;
                     r_rsp_flags  <= 4'd0;
                     r_rsp_err    <= 1'b1;
                     r_rsp_valid  <= 1'b1;
                     r_state      <= ST_RESP;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               r_rsp_result <= alu_out;
               r_rsp_flags  <= clean_flags(r_alu_op, alu_zf, alu_cf, alu_of, alu_sf);
               r_rsp_err    <= 1'b0;
               r_rsp_valid  <= 1'b1;
               r_state      <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end else begin
                  r_state <= ST_RESP;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_op     = r_alu_op;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_tag    = r_rsp_tag;
   assign rsp_result = r_rsp_result;
   assign rsp_flags  = r_rsp_flags;
   assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table of directed vectors, a few
// hand-written multi-cycle sequences and a randomized phase, all checked
// by a cycle monitor holding an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_arbiter;

   localparam int TAG_W = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0]       req0_a, req0_b, req1_a, req1_b;
   logic [3:0]        req0_op, req1_op;
   logic [TAG_W-1:0]  req0_tag, req1_tag;
   logic              rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [TAG_W-1:0]  rsp_tag;
   logic [31:0]       rsp_result, alu_a, alu_b, alu_out;
   logic [3:0]        rsp_flags, alu_op;
   logic              alu_zf, alu_cf, alu_of, alu_sf;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        id;
      logic [3:0]  tag;
      logic [31:0] result;
      logic [3:0]  flags;
      logic        err;
   } rsp_t;

   typedef struct packed {
      logic        port;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] res;
      logic [3:0]  flags;
      logic        err;
   } vec_t;

   alu_arbiter #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
      .req0_b(req0_b), .req0_op(req0_op), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
      .req1_b(req1_b), .req1_op(req1_op), .req1_tag(req1_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_out(alu_out), .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_of(alu_of),
      .alu_sf(alu_sf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic b_legal(input logic [3:0] op);
      return (op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11, 4'd13});
   endfunction

   function automatic logic b_arith(input logic [3:0] op);
      return (op inside {4'd0, 4'd8, 4'd10, 4'd11});
   endfunction

   // {carry, overflow, result} of the operation in plain arithmetic
   function automatic logic [33:0] alu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, o;
      c = 1'b0; o = 1'b0; r = 32'd0;
      case (op)
         4'd0:  begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                      o = (a[31] == b[31]) && (r[31] != a[31]); end
         4'd8:  begin r = a - b; c = (a < b); o = (a[31] != b[31]) && (r[31] != a[31]); end
         4'd10: begin r = a + 32'd1; c = (a == 32'hFFFF_FFFF); o = (a == 32'h7FFF_FFFF); end
         4'd11: begin r = a - 32'd1; c = (a == 32'd0); o = (a == 32'h8000_0000); end
         4'd1:  r = a << b[4:0];
         4'd2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd3:  r = (a < b) ? 32'd1 : 32'd0;
         4'd4:  r = a ^ b;
         4'd5:  r = a >> b[4:0];
         4'd6:  r = a | b;
         4'd7:  r = a & b;
         4'd13: r = $unsigned($signed(a) >>> b[4:0]);
         default: r = 32'd0;
      endcase
      return {c, o, r};
   endfunction

   function automatic rsp_t ref_rsp(input logic id, input logic [3:0] tag, input logic [3:0] op,
                                    input logic [31:0] a, input logic [31:0] b);
      rsp_t        r;
      logic [33:0] t;
      r.id = id; r.tag = tag;
      if (!b_legal(op)) begin
         r.result = 32'd0; r.flags = 4'd0; r.err = 1'b1;
      end else begin
         t = alu_calc(op, a, b);
         r.result = t[31:0];
         r.err    = 1'b0;
         r.flags  = {(t[31:0] == 32'd0), b_arith(op) & t[33], b_arith(op) & t[32], t[31]};
      end
      return r;
   endfunction

   // External ALU: drives junk carry/overflow on logic ops
   logic [33:0] env_t;
   always_comb begin
      env_t   = alu_calc(alu_op, alu_a, alu_b);
      alu_out = env_t[31:0];
      alu_zf  = (env_t[31:0] == 32'd0);
      alu_sf  = env_t[31];
      alu_cf  = env_t[33] | ~b_arith(alu_op);
      alu_of  = env_t[32] | ~b_arith(alu_op);
   end

   // Reference model and monitor, sampled on the falling edge
   rsp_t        exp_q[$];
   int          m_ptr, m_busy, lat_cnt, lat_exp, g;
   bit          hold_on;
   rsp_t        held, cur, e;
   logic [31:0] m_alu_a, m_alu_b, fa, fb;
   logic [3:0]  m_alu_op, fo, ft;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_ptr = 0; m_busy = 0; lat_cnt = -1; lat_exp = 0; hold_on = 1'b0;
         m_alu_a = 32'd0; m_alu_b = 32'd0; m_alu_op = 4'd0;
      end else begin
         g = -1;
         if (m_busy == 0) begin
            if (m_ptr == 0) g = req0_valid ? 0 : (req1_valid ? 1 : -1);
            else            g = req1_valid ? 1 : (req0_valid ? 0 : -1);
         end
         chk("mon_req0_ready", req0_ready, (g == 0));
         chk("mon_req1_ready", req1_ready, (g == 1));
         chk("mon_alu_a", alu_a, m_alu_a);
         chk("mon_alu_b", alu_b, m_alu_b);
         chk("mon_alu_op", alu_op, m_alu_op);
         cur = {rsp_id, rsp_tag, rsp_result, rsp_flags, rsp_err};
         if (hold_on) chk("mon_rsp_stable", cur, held);
         hold_on = rsp_valid && !rsp_ready;
         held    = cur;
         if (lat_cnt >= 0) begin
            lat_cnt++;
            if (rsp_valid || lat_cnt >= lat_exp) begin
               chk("mon_rsp_latency", rsp_valid ? lat_cnt : 99, lat_exp);
               lat_cnt = -1;
            end
         end
         if (rsp_valid && rsp_ready) begin
            chk("mon_rsp_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("mon_rsp_id", rsp_id, e.id);
               chk("mon_rsp_tag", rsp_tag, e.tag);
               chk("mon_rsp_result", rsp_result, e.result);
               chk("mon_rsp_flags", rsp_flags, e.flags);
               chk("mon_rsp_err", rsp_err, e.err);
            end
            m_busy = 0;
         end
         if (g >= 0) begin
            if (g == 0) begin fa = req0_a; fb = req0_b; fo = req0_op; ft = req0_tag; end
            else        begin fa = req1_a; fb = req1_b; fo = req1_op; ft = req1_tag; end
            exp_q.push_back(ref_rsp(g[0], ft, fo, fa, fb));
            if (b_legal(fo)) begin m_alu_a = fa; m_alu_b = fb; m_alu_op = fo; end
            lat_exp = b_legal(fo) ? 2 : 1;
            lat_cnt = 0;
            m_ptr   = 1 - g;
            m_busy  = 1;
         end
      end
   end

   task automatic drive(input int p, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag);
      if (p == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag; end
      else        begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag; end
   endtask

   // Present a request on one port and hold it until it is accepted
   task automatic send(input int p, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
      bit got;
      got = 1'b0;
      drive(p, op, a, b, tag);
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) got = 1'b1;
         else @(posedge clk);
      end
      chk("grant_timeout", got, 1'b1);
      @(posedge clk); #1;
      if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
   endtask

   task automatic wait_rsp(output rsp_t r);
      bit ok;
      ok = 1'b0;
      r  = '0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            ok = 1'b1;
            r  = {rsp_id, rsp_tag, rsp_result, rsp_flags, rsp_err};
         end
      end
      chk("rsp_timeout", ok, 1'b1);
      @(posedge clk); #1;
   endtask

   // Both ports already driven; serve them and report grant order
   task automatic run_pair(output int first, output rsp_t r0, output rsp_t r1);
      int   got;
      rsp_t r;
      first = -1; r0 = '0; r1 = '0;
      for (int k = 0; k < 2; k++) begin
         got = -1;
         for (int n = 0; n < 50 && got < 0; n++) begin
            @(negedge clk);
            if (req0_valid && req0_ready)      got = 0;
            else if (req1_valid && req1_ready) got = 1;
            else @(posedge clk);
         end
         chk("pair_grant_timeout", (got >= 0), 1'b1);
         @(posedge clk); #1;
         if (got == 0) req0_valid = 1'b0; else if (got == 1) req1_valid = 1'b0;
         if (k == 0) first = got;
         wait_rsp(r);
         if (k == 0) r0 = r; else r1 = r;
      end
   endtask

   vec_t       vt[17];
   rsp_t       r, r0, r1, snap;
   int         first;
   logic [3:0] last_legal;
   bit         seen;

   initial begin
      req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b1;
      req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'd0; req0_tag = 4'd0;
      req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'd0; req1_tag = 4'd0;

      //          port  op     a             b             tag    result        ZCOS     err
      vt[0]  = '{1'b0, 4'h0, 32'd5,        32'd7,        4'h3, 32'd12,        4'b0000, 1'b0};
      vt[1]  = '{1'b0, 4'h4, 32'hDEADBEEF, 32'hDEADBEEF, 4'h5, 32'd0,         4'b1000, 1'b0};
      vt[2]  = '{1'b1, 4'hF, 32'h1234,     32'h5678,     4'h6, 32'd0,         4'b0000, 1'b1};
      vt[3]  = '{1'b0, 4'h8, 32'd0,        32'd1,        4'h7, 32'hFFFFFFFF,  4'b0101, 1'b0};
      vt[4]  = '{1'b1, 4'h0, 32'h7FFFFFFF, 32'd1,        4'h8, 32'h80000000,  4'b0011, 1'b0};
      vt[5]  = '{1'b0, 4'h0, 32'hFFFFFFFF, 32'd1,        4'h9, 32'd0,         4'b1100, 1'b0};
      vt[6]  = '{1'b1, 4'h2, 32'hFFFFFFFF, 32'd1,        4'hA, 32'd1,         4'b0000, 1'b0};
      vt[7]  = '{1'b0, 4'h3, 32'hFFFFFFFF, 32'd1,        4'hB, 32'd0,         4'b1000, 1'b0};
      vt[8]  = '{1'b1, 4'hD, 32'h80000000, 32'd4,        4'hC, 32'hF8000000,  4'b0001, 1'b0};
      vt[9]  = '{1'b0, 4'h1, 32'd1,        32'd31,       4'hD, 32'h80000000,  4'b0001, 1'b0};
      vt[10] = '{1'b1, 4'h9, 32'd1,        32'd1,        4'hE, 32'd0,         4'b0000, 1'b1};
      vt[11] = '{1'b0, 4'hB, 32'd0,        32'd0,        4'hF, 32'hFFFFFFFF,  4'b0101, 1'b0};
      vt[12] = '{1'b1, 4'hA, 32'hFFFFFFFF, 32'd0,        4'h1, 32'd0,         4'b1100, 1'b0};
      vt[13] = '{1'b0, 4'h7, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'h2, 32'd0,         4'b1000, 1'b0};
      vt[14] = '{1'b0, 4'h8, 32'h80000000, 32'd1,        4'h5, 32'h7FFFFFFF,  4'b0010, 1'b0};
      vt[15] = '{1'b1, 4'h5, 32'h80000000, 32'd31,       4'h3, 32'd1,         4'b0000, 1'b0};
      vt[16] = '{1'b1, 4'h6, 32'd0,        32'd0,        4'h4, 32'd0,         4'b1000, 1'b0};

      // Reset state, with a request already pending on port 0
      #2;
      chk("reset_req0_ready", req0_ready, 1'b0);
      chk("reset_req1_ready", req1_ready, 1'b0);
      chk("reset_rsp", {rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_flags, rsp_err}, 64'd0);
      chk("reset_alu", {alu_op, alu_a}, 64'd0);
      chk("reset_alu_b", alu_b, 32'd0);
      req0_valid = 1'b0;
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed single-op vectors
      last_legal = 4'd0;
      for (int i = 0; i < 17; i++) begin
         send(int'(vt[i].port), vt[i].op, vt[i].a, vt[i].b, vt[i].tag);
         wait_rsp(r);
         chk($sformatf("vec%0d_id", i), r.id, vt[i].port);
         chk($sformatf("vec%0d_tag", i), r.tag, vt[i].tag);
         chk($sformatf("vec%0d_result", i), r.result, vt[i].res);
         chk($sformatf("vec%0d_flags", i), r.flags, vt[i].flags);
         chk($sformatf("vec%0d_err", i), r.err, vt[i].err);
         if (vt[i].err) chk($sformatf("vec%0d_alu_op_kept", i), alu_op, last_legal);
         else last_legal = vt[i].op;
      end

      // Simultaneous requests: pointer is at port 0 after a port-1 op
      drive(0, 4'h0, 32'd1, 32'd1, 4'h1);
      drive(1, 4'h8, 32'd0, 32'd1, 4'h2);
      run_pair(first, r0, r1);
      chk("pair1_first", first, 0);
      chk("pair1_rsp0", {r0.id, r0.result, r0.flags}, {1'b0, 32'd2, 4'b0000});
      chk("pair1_rsp1", {r1.id, r1.result, r1.flags}, {1'b1, 32'hFFFFFFFF, 4'b0101});
      send(0, 4'h6, 32'd3, 32'd4, 4'h3);
      wait_rsp(r);
      drive(0, 4'h0, 32'd10, 32'd20, 4'h4);
      drive(1, 4'h0, 32'd30, 32'd40, 4'h5);
      run_pair(first, r0, r1);
      chk("pair2_first", first, 1);
      chk("pair2_rsp0", {r0.id, r0.result}, {1'b1, 32'd70});
      chk("pair2_rsp1", {r1.id, r1.result}, {1'b0, 32'd30});

      // Back-pressure: response held stable, port 1 kept waiting
      rsp_ready = 1'b0;
      send(0, 4'h6, 32'hF0, 32'h0F, 4'h6);
      drive(1, 4'h7, 32'hFF, 32'h0F, 4'h7);
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("bp_rsp_seen", seen, 1'b1);
      snap = {rsp_id, rsp_tag, rsp_result, rsp_flags, rsp_err};
      chk("bp_rsp_value", snap, {1'b0, 4'h6, 32'hFF, 4'b0000, 1'b0});
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk("bp_rsp_hold", {rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_flags, rsp_err}, {1'b1, snap});
         chk("bp_req1_blocked", req1_ready, 1'b0);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("bp_req1_granted_next", req1_ready, 1'b1);
      @(posedge clk); #1 req1_valid = 1'b0;
      wait_rsp(r);
      chk("bp_port1_rsp", {r.id, r.tag, r.result, r.flags}, {1'b1, 4'h7, 32'h0F, 4'b0000});

      // Reset while the ALU op is in EXEC
      send(0, 4'h0, 32'h11, 32'h22, 4'h8);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_rsp", {rsp_valid, rsp_result, rsp_flags, rsp_err, rsp_tag}, 64'd0);
      chk("midrst_alu", {alu_op, alu_a}, 64'd0);
      chk("midrst_alu_b", alu_b, 32'd0);
      @(negedge clk); #2 rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         chk("midrst_no_rsp", rsp_valid, 1'b0);
      end
      @(posedge clk); #1;
      send(1, 4'h0, 32'd2, 32'd3, 4'h9);
      wait_rsp(r);
      chk("midrst_next_rsp", {r.id, r.tag, r.result, r.err}, {1'b1, 4'h9, 32'd5, 1'b0});

      // Randomized traffic checked by the monitor
      for (int c = 0; c < 600; c++) begin
         req0_valid = ($urandom_range(1, 0) == 1);
         req1_valid = ($urandom_range(1, 0) == 1);
         req0_op    = 4'($urandom_range(15, 0));
         req1_op    = 4'($urandom_range(15, 0));
         req0_a     = ($urandom_range(3, 0) == 0) ? 32'h7FFFFFFF : $urandom;
         req0_b     = ($urandom_range(3, 0) == 0) ? 32'd1 : $urandom;
         req1_a     = ($urandom_range(3, 0) == 0) ? 32'hFFFFFFFF : $urandom;
         req1_b     = $urandom;
         req0_tag   = 4'($urandom_range(15, 0));
         req1_tag   = 4'($urandom_range(15, 0));
         rsp_ready  = ($urandom_range(3, 0) != 0);
         @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      for (int n = 0; n < 20 && m_busy != 0; n++) @(posedge clk);
      @(negedge clk); @(negedge clk);
      chk("final_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
